// File: rtl/unid_control_mc_if.sv
`default_nettype none
// =====================================================================
// unid_control_mc_if : IR fields / status in, datapath controls out
// Rev 1.0
// =====================================================================
interface unid_control_mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_ovf;
  logic       div_zero;
  logic       dm_done;

  logic       pc_write;
  logic       pc_write_cond;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       epc_write;
  logic       dm_start;
  logic       hi_lo_write;
  logic [1:0] i_or_d;
  logic [2:0] mem_to_reg;
  logic [2:0] pc_src;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] reg_dst;
  logic [1:0] cause;

  modport master (
    input  opcode, funct, alu_ovf, div_zero, dm_done,
    output pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write,
           epc_write, dm_start, hi_lo_write, i_or_d, mem_to_reg, pc_src,
           alu_op, alu_src_a, alu_src_b, reg_dst, cause
  );

  modport slave (
    output opcode, funct, alu_ovf, div_zero, dm_done,
    input  pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write,
           epc_write, dm_start, hi_lo_write, i_or_d, mem_to_reg, pc_src,
           alu_op, alu_src_a, alu_src_b, reg_dst, cause
  );
endinterface
`default_nettype wire

// File: rtl/unid_control_mc.sv
`default_nettype none
// =====================================================================
// unid_control_mc : multicycle MIPS control FSM with memory wait states,
// div/mul handshake and precise exception entry.          Rev 1.0
// =====================================================================
module unid_control_mc #(
  parameter int unsigned MEM_WAIT = 0,
  parameter bit          XCPT_EN  = 1'b1
) (
  input wire logic          clk,
  input wire logic          reset,
  unid_control_mc_if.master ctl
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] WAIT_N   = 3'(MEM_WAIT);
  localparam logic [2:0] WAIT_M1  = 3'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_FETCH_W, S_DECODE, S_R_ALU, S_R_WB, S_I_ALU, S_I_WB,
    S_LUI, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP,
    S_JAL, S_JR, S_DM_START, S_DM_WAIT, S_DM_WB, S_XCPT_SAVE, S_XCPT_JMP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       epc_write;
    logic       dm_start;
    logic       hi_lo_write;
    logic [1:0] i_or_d;
    logic [2:0] mem_to_reg;
    logic [2:0] pc_src;
    logic [2:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  ctrl_t      out_q, out_d;

  logic       is_rtype, is_addsub, ovf_kill, dm_kill;
  logic [2:0] r_op;

  assign is_rtype  = (ctl.opcode == OP_RTYPE);
  assign is_addsub = (ctl.funct == FN_ADD) || (ctl.funct == FN_SUB);

  // Input-dependent suppression: the registered strobe is masked in the
  // very cycle the fault is seen, so no write ever leaks out.
  assign ovf_kill = XCPT_EN && ctl.alu_ovf &&
                    (((state_q == S_R_WB) && is_addsub) || (state_q == S_I_WB));
  assign dm_kill  = XCPT_EN && ctl.div_zero && (ctl.funct == FN_DIV) &&
                    (state_q == S_DM_START);

  always_comb begin
    case (ctl.funct)
      FN_SUB:  r_op = 3'b010;
      FN_AND:  r_op = 3'b011;
      FN_SLT:  r_op = 3'b111;
      default: r_op = 3'b001;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH: begin
        if (MEM_WAIT == 0) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH_W;
          cnt_d   = WAIT_M1;
        end
      end
      S_FETCH_W: begin
        if (cnt_q == 3'd0) state_d = S_DECODE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_DECODE: begin
        if (is_rtype && (is_addsub || ctl.funct == FN_AND || ctl.funct == FN_SLT))
          state_d = S_R_ALU;
        else if (is_rtype && (ctl.funct == FN_MULT || ctl.funct == FN_DIV))
          state_d = S_DM_START;
        else if (is_rtype && ctl.funct == FN_JR)
          state_d = S_JR;
        else if (ctl.opcode == OP_ADDI)
          state_d = S_I_ALU;
        else if (ctl.opcode == OP_LUI)
          state_d = S_LUI;
        else if (ctl.opcode == OP_LW || ctl.opcode == OP_SW)
          state_d = S_MEM_ADDR;
        else if (ctl.opcode == OP_BEQ || ctl.opcode == OP_BNE)
          state_d = S_BRANCH;
        else if (ctl.opcode == OP_J)
          state_d = S_JUMP;
        else if (ctl.opcode == OP_JAL)
          state_d = S_JAL;
        else if (XCPT_EN) begin
          state_d = S_XCPT_SAVE;
          cause_d = 2'b00;
        end else
          state_d = S_FETCH;
      end
      S_R_ALU:   state_d = S_R_WB;
      S_I_ALU:   state_d = S_I_WB;
      S_R_WB, S_I_WB: begin
        if (ovf_kill) begin
          state_d = S_XCPT_SAVE;
          cause_d = 2'b01;
        end else
          state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        if (ctl.opcode == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
          cnt_d   = WAIT_N;
        end
      end
      S_MEM_RD: begin
        if (cnt_q == 3'd0) state_d = S_MEM_WB;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_DM_START: begin
        if (dm_kill) begin
          state_d = S_XCPT_SAVE;
          cause_d = 2'b10;
        end else
          state_d = S_DM_WAIT;
      end
      S_DM_WAIT:   if (ctl.dm_done) state_d = S_DM_WB;
      S_XCPT_SAVE: state_d = S_XCPT_JMP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they land in a register
  // aligned with the state they belong to.
  always_comb begin
    out_d = '0;
    case (state_d)
      S_FETCH, S_FETCH_W: begin
        out_d.mem_read  = 1'b1;
        out_d.alu_src_b = 2'b01;
        out_d.alu_op    = 3'b001;
        out_d.ir_write  = (state_d == S_FETCH_W) ? (cnt_d == 3'd0) : (MEM_WAIT == 0);
        out_d.pc_write  = out_d.ir_write;
      end
      S_DECODE: begin
        out_d.alu_src_b = 2'b11;
        out_d.alu_op    = 3'b001;
      end
      S_R_ALU, S_R_WB: begin
        out_d.alu_src_a = 2'b01;
        out_d.alu_op    = r_op;
        if (state_d == S_R_WB) begin
          out_d.reg_dst   = 2'b01;
          out_d.reg_write = 1'b1;
        end
      end
      S_I_ALU, S_I_WB, S_MEM_ADDR: begin
        out_d.alu_src_a = 2'b01;
        out_d.alu_src_b = 2'b10;
        out_d.alu_op    = 3'b001;
        out_d.reg_write = (state_d == S_I_WB);
      end
      S_LUI: begin
        out_d.reg_write  = 1'b1;
        out_d.mem_to_reg = 3'b011;
      end
      S_MEM_RD: begin
        out_d.mem_read = 1'b1;
        out_d.i_or_d   = 2'b01;
      end
      S_MEM_WB: begin
        out_d.reg_write  = 1'b1;
        out_d.mem_to_reg = 3'b001;
      end
      S_MEM_WR: begin
        out_d.mem_write = 1'b1;
        out_d.i_or_d    = 2'b01;
      end
      S_BRANCH: begin
        out_d.alu_src_a     = 2'b01;
        out_d.alu_op        = 3'b010;
        out_d.pc_write_cond = 1'b1;
        out_d.pc_src        = 3'b001;
      end
      S_JUMP: begin
        out_d.pc_write = 1'b1;
        out_d.pc_src   = 3'b010;
      end
      S_JAL: begin
        out_d.reg_write  = 1'b1;
        out_d.reg_dst    = 2'b10;
        out_d.mem_to_reg = 3'b010;
        out_d.pc_write   = 1'b1;
        out_d.pc_src     = 3'b010;
      end
      S_JR: begin
        out_d.pc_write = 1'b1;
        out_d.pc_src   = 3'b011;
      end
      S_DM_START:  out_d.dm_start    = 1'b1;
      S_DM_WB:     out_d.hi_lo_write = 1'b1;
      S_XCPT_SAVE: begin
        out_d.epc_write = 1'b1;
        out_d.alu_src_b = 2'b01;
        out_d.alu_op    = 3'b010;
      end
      S_XCPT_JMP: begin
        out_d.pc_write = 1'b1;
        out_d.pc_src   = 3'b100;
      end
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= 3'd0;
      cause_q <= 2'b00;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      out_q   <= out_d;
    end
  end

  assign ctl.pc_write      = out_q.pc_write;
  assign ctl.pc_write_cond = out_q.pc_write_cond;
  assign ctl.mem_read      = out_q.mem_read;
  assign ctl.mem_write     = out_q.mem_write;
  assign ctl.ir_write      = out_q.ir_write;
  assign ctl.reg_write     = out_q.reg_write & ~ovf_kill;
  assign ctl.epc_write     = out_q.epc_write;
  assign ctl.dm_start      = out_q.dm_start & ~dm_kill;
  assign ctl.hi_lo_write   = out_q.hi_lo_write;
  assign ctl.i_or_d        = out_q.i_or_d;
  assign ctl.mem_to_reg    = out_q.mem_to_reg;
  assign ctl.pc_src        = out_q.pc_src;
  assign ctl.alu_op        = out_q.alu_op;
  assign ctl.alu_src_a     = out_q.alu_src_a;
  assign ctl.alu_src_b     = out_q.alu_src_b;
  assign ctl.reg_dst       = out_q.reg_dst;
  assign ctl.cause         = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_unid_control_mc.sv
`default_nettype none
// =====================================================================
// tb_unid_control_mc : directed checks on three parameterisations.
// Rev 1.0
// =====================================================================
module tb_unid_control_mc;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic       alu_ovf = 1'b0, div_zero = 1'b0, dm_done = 1'b0;
  int         n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  // a: MEM_WAIT=0 exceptions on; b: MEM_WAIT=2; c: exceptions off
  unid_control_mc_if ifa ();
  unid_control_mc_if ifb ();
  unid_control_mc_if ifc ();

  assign ifa.opcode = opcode;  assign ifa.funct = funct;  assign ifa.alu_ovf = alu_ovf;
  assign ifa.div_zero = div_zero;  assign ifa.dm_done = dm_done;
  assign ifb.opcode = opcode;  assign ifb.funct = funct;  assign ifb.alu_ovf = alu_ovf;
  assign ifb.div_zero = div_zero;  assign ifb.dm_done = dm_done;
  assign ifc.opcode = opcode;  assign ifc.funct = funct;  assign ifc.alu_ovf = alu_ovf;
  assign ifc.div_zero = div_zero;  assign ifc.dm_done = dm_done;

  unid_control_mc #(.MEM_WAIT(0), .XCPT_EN(1'b1)) u_a (.clk(clk), .reset(rst_a), .ctl(ifa));
  unid_control_mc #(.MEM_WAIT(2), .XCPT_EN(1'b1)) u_b (.clk(clk), .reset(rst_b), .ctl(ifb));
  unid_control_mc #(.MEM_WAIT(0), .XCPT_EN(1'b0)) u_c (.clk(clk), .reset(rst_c), .ctl(ifc));

  logic [27:0] va, vb;
  assign va = {ifa.pc_write, ifa.pc_write_cond, ifa.mem_read, ifa.mem_write, ifa.ir_write,
               ifa.reg_write, ifa.epc_write, ifa.dm_start, ifa.hi_lo_write, ifa.i_or_d,
               ifa.mem_to_reg, ifa.pc_src, ifa.alu_op, ifa.alu_src_a, ifa.alu_src_b,
               ifa.reg_dst, ifa.cause};
  assign vb = {ifb.pc_write, ifb.pc_write_cond, ifb.mem_read, ifb.mem_write, ifb.ir_write,
               ifb.reg_write, ifb.epc_write, ifb.dm_start, ifb.hi_lo_write, ifb.i_or_d,
               ifb.mem_to_reg, ifb.pc_src, ifb.alu_op, ifb.alu_src_a, ifb.alu_src_b,
               ifb.reg_dst, ifb.cause};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the release negedge: every instance sits in RST (k=0).
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  initial begin
    // ---- mult handshake, reset mid-DM_WAIT, wait-state fetch
    opcode = 6'h00; funct = 6'h18; alu_ovf = 1'b0; div_zero = 1'b0; dm_done = 1'b0;
    do_reset();
    chk("rst_a_all0", 32'(va), 0);
    chk("rst_b_all0", 32'(vb), 0);
    cyc(1);
    chk("a_fetch_mem_read", 32'(ifa.mem_read), 1);
    chk("a_fetch_ir_write", 32'(ifa.ir_write), 1);
    chk("a_fetch_pc_write", 32'(ifa.pc_write), 1);
    chk("a_fetch_alu_op", 32'(ifa.alu_op), 1);
    chk("a_fetch_alu_src_b", 32'(ifa.alu_src_b), 1);
    chk("b_fetch1_mem_read", 32'(ifb.mem_read), 1);
    chk("b_fetch1_ir_write", 32'(ifb.ir_write), 0);
    cyc(1);
    chk("a_decode_alu_src_b", 32'(ifa.alu_src_b), 3);
    chk("a_decode_mem_read", 32'(ifa.mem_read), 0);
    chk("b_fetch2_ir_write", 32'(ifb.ir_write), 0);
    cyc(1);
    chk("a_mult_dm_start", 32'(ifa.dm_start), 1);
    chk("b_fetch3_mem_read", 32'(ifb.mem_read), 1);
    chk("b_fetch3_ir_write", 32'(ifb.ir_write), 1);
    cyc(1);
    chk("a_dmwait_dm_start", 32'(ifa.dm_start), 0);
    chk("b_decode_mem_read", 32'(ifb.mem_read), 0);
    cyc(1);
    chk("b_mult_dm_start", 32'(ifb.dm_start), 1);
    cyc(2);
    chk("a_dmwait_hilo_k7", 32'(ifa.hi_lo_write), 0);
    #2 rst_b = 1'b0;
    #1 chk("b_async_rst_dmwait", 32'(vb), 0);
    @(negedge clk) rst_b = 1'b1;
    chk("b_rst_state", 32'(vb), 0);
    cyc(1);
    chk("b_refetch1_mem_read", 32'(ifb.mem_read), 1);
    chk("b_refetch1_ir_write", 32'(ifb.ir_write), 0);
    cyc(1);
    chk("b_refetch2_ir_write", 32'(ifb.ir_write), 0);
    chk("a_dmwait_hilo_k10", 32'(ifa.hi_lo_write), 0);
    dm_done = 1'b1;
    cyc(1);
    chk("b_refetch3_ir_write", 32'(ifb.ir_write), 1);
    chk("a_dmwb_hilo", 32'(ifa.hi_lo_write), 1);
    cyc(1);
    chk("a_after_dmwb_hilo", 32'(ifa.hi_lo_write), 0);
    chk("a_after_dmwb_fetch", 32'(ifa.mem_read), 1);
    cyc(1);
    chk("b_done_early_dm_start", 32'(ifb.dm_start), 1);
    cyc(1);
    chk("b_done_early_wait_hilo", 32'(ifb.hi_lo_write), 0);
    cyc(1);
    chk("b_done_early_dmwb_hilo", 32'(ifb.hi_lo_write), 1);

    // ---- add with overflow, then undefined opcode
    opcode = 6'h00; funct = 6'h20; alu_ovf = 1'b1; dm_done = 1'b0;
    do_reset();
    cyc(3);
    chk("a_add_alu_src_a", 32'(ifa.alu_src_a), 1);
    chk("a_add_alu_op", 32'(ifa.alu_op), 1);
    cyc(1);
    chk("a_add_ovf_reg_write", 32'(ifa.reg_write), 0);
    chk("a_add_reg_dst", 32'(ifa.reg_dst), 1);
    chk("a_cause_before", 32'(ifa.cause), 0);
    chk("c_add_ovf_reg_write", 32'(ifc.reg_write), 1);
    cyc(1);
    chk("a_ovf_epc_write", 32'(ifa.epc_write), 1);
    chk("a_ovf_cause", 32'(ifa.cause), 1);
    chk("a_ovf_alu_op", 32'(ifa.alu_op), 2);
    chk("a_ovf_save_reg_write", 32'(ifa.reg_write), 0);
    chk("c_noxcpt_fetch", 32'(ifc.mem_read), 1);
    chk("c_noxcpt_epc", 32'(ifc.epc_write), 0);
    cyc(1);
    chk("a_ovf_jmp_pc_write", 32'(ifa.pc_write), 1);
    chk("a_ovf_jmp_pc_src", 32'(ifa.pc_src), 4);
    cyc(1);
    chk("a_ovf_refetch", 32'(ifa.mem_read), 1);
    chk("a_ovf_cause_held", 32'(ifa.cause), 1);
    opcode = 6'h3F;
    cyc(2);
    chk("a_undef_epc_write", 32'(ifa.epc_write), 1);
    chk("a_undef_cause", 32'(ifa.cause), 0);

    // ---- div by zero, async reset mid-FETCH_W and cause clear
    opcode = 6'h00; funct = 6'h1A; alu_ovf = 1'b0; div_zero = 1'b1;
    do_reset();
    cyc(2);
    chk("b_fetchw_mem_read", 32'(ifb.mem_read), 1);
    #2 rst_b = 1'b0;
    #1 chk("b_async_rst_fetchw", 32'(ifb.mem_read), 0);
    @(negedge clk) rst_b = 1'b1;
    chk("a_div0_dm_start", 32'(ifa.dm_start), 0);
    chk("c_div0_dm_start", 32'(ifc.dm_start), 1);
    cyc(1);
    chk("a_div0_epc_write", 32'(ifa.epc_write), 1);
    chk("a_div0_cause", 32'(ifa.cause), 2);
    chk("a_div0_no_start", 32'(ifa.dm_start), 0);
    cyc(1);
    chk("a_div0_jmp_pc_src", 32'(ifa.pc_src), 4);
    cyc(1);
    chk("a_div0_cause_held", 32'(ifa.cause), 2);
    #2 rst_a = 1'b0;
    #1 chk("a_async_rst_all0", 32'(va), 0);
    @(negedge clk) rst_a = 1'b1;

    // ---- lw (both wait settings)
    opcode = 6'h23; funct = 6'h00; div_zero = 1'b0;
    do_reset();
    cyc(3);
    chk("a_lw_addr_src_b", 32'(ifa.alu_src_b), 2);
    chk("a_lw_addr_src_a", 32'(ifa.alu_src_a), 1);
    cyc(1);
    chk("a_lw_rd_mem_read", 32'(ifa.mem_read), 1);
    chk("a_lw_rd_i_or_d", 32'(ifa.i_or_d), 1);
    cyc(1);
    chk("a_lw_wb_reg_write", 32'(ifa.reg_write), 1);
    chk("a_lw_wb_mem_to_reg", 32'(ifa.mem_to_reg), 1);
    chk("a_lw_wb_mem_read", 32'(ifa.mem_read), 0);
    cyc(1);
    chk("a_lw_next_fetch", 32'(ifa.ir_write), 1);
    chk("b_lw_rd1_i_or_d", 32'(ifb.i_or_d), 1);
    cyc(2);
    chk("b_lw_rd3_mem_read", 32'(ifb.mem_read), 1);
    cyc(1);
    chk("b_lw_wb_reg_write", 32'(ifb.reg_write), 1);
    chk("b_lw_wb_mem_read", 32'(ifb.mem_read), 0);

    // ---- sw
    opcode = 6'h2B;
    do_reset();
    cyc(3);
    chk("a_sw_addr_mem_write", 32'(ifa.mem_write), 0);
    cyc(1);
    chk("a_sw_mem_write", 32'(ifa.mem_write), 1);
    chk("a_sw_i_or_d", 32'(ifa.i_or_d), 1);
    cyc(1);
    chk("a_sw_after_mem_write", 32'(ifa.mem_write), 0);
    chk("a_sw_after_fetch", 32'(ifa.mem_read), 1);

    // ---- jal
    opcode = 6'h03;
    do_reset();
    cyc(3);
    chk("a_jal_reg_dst", 32'(ifa.reg_dst), 2);
    chk("a_jal_mem_to_reg", 32'(ifa.mem_to_reg), 2);
    chk("a_jal_pc_write", 32'(ifa.pc_write), 1);
    chk("a_jal_pc_src", 32'(ifa.pc_src), 2);
    chk("a_jal_reg_write", 32'(ifa.reg_write), 1);
    cyc(1);
    chk("a_jal_next_fetch", 32'(ifa.mem_read), 1);

    // ---- addi with overflow
    opcode = 6'h08; funct = 6'h00; alu_ovf = 1'b1;
    do_reset();
    cyc(3);
    chk("a_addi_alu_src_b", 32'(ifa.alu_src_b), 2);
    cyc(1);
    chk("a_addi_ovf_reg_write", 32'(ifa.reg_write), 0);
    chk("c_addi_ovf_reg_write", 32'(ifc.reg_write), 1);
    cyc(1);
    chk("a_addi_ovf_cause", 32'(ifa.cause), 1);

    // ---- slt ignores overflow
    opcode = 6'h00; funct = 6'h2A; alu_ovf = 1'b1;
    do_reset();
    cyc(3);
    chk("a_slt_alu_op", 32'(ifa.alu_op), 7);
    cyc(1);
    chk("a_slt_reg_write", 32'(ifa.reg_write), 1);
    cyc(1);
    chk("a_slt_next_fetch", 32'(ifa.mem_read), 1);
    chk("a_slt_no_epc", 32'(ifa.epc_write), 0);

    // ---- undefined opcode with exceptions disabled, then beq
    opcode = 6'h3F; funct = 6'h00; alu_ovf = 1'b0;
    do_reset();
    cyc(3);
    chk("c_undef_fetch", 32'(ifc.mem_read), 1);
    chk("c_undef_no_epc", 32'(ifc.epc_write), 0);
    opcode = 6'h04;
    do_reset();
    cyc(3);
    chk("a_beq_pc_write_cond", 32'(ifa.pc_write_cond), 1);
    chk("a_beq_pc_src", 32'(ifa.pc_src), 1);
    chk("a_beq_alu_op", 32'(ifa.alu_op), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
